// File: rtl/axil_pkg.sv
// Shared AXI-Lite constants, write-channel state encoding and byte-strobe merge helper.
package axil_pkg;

  localparam int AXIL_DATA_W = 32;
  localparam int AXIL_ADDR_W = 32;

  localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_AW,
    WR_W,
    WR_BOTH,
    WR_RESP
  } wr_state_e;

  // Merge write data into an existing word, one byte lane per strobe bit.
  function automatic logic [AXIL_DATA_W-1:0] apply_wstrb(
    input logic [AXIL_DATA_W-1:0]   old,
    input logic [AXIL_DATA_W-1:0]   data,
    input logic [AXIL_DATA_W/8-1:0] strb
  );
    logic [AXIL_DATA_W-1:0] res;
    res = old;
    for (int b = 0; b < AXIL_DATA_W / 8; b++) begin
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_csr_slave_if.sv
// AXI-Lite bus bundle between the upstream bridge (master) and the CSR bank (slave).
interface axil_csr_slave_if;
  import axil_pkg::*;

  logic                     awvalid;
  logic                     awready;
  logic [AXIL_ADDR_W-1:0]   awaddr;
  logic                     wvalid;
  logic                     wready;
  logic [AXIL_DATA_W-1:0]   wdata;
  logic [AXIL_DATA_W/8-1:0] wstrb;
  logic                     bvalid;
  logic                     bready;
  logic [1:0]               bresp;
  logic                     arvalid;
  logic                     arready;
  logic [AXIL_ADDR_W-1:0]   araddr;
  logic                     rvalid;
  logic                     rready;
  logic [AXIL_DATA_W-1:0]   rdata;
  logic [1:0]               rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axil_csr_wr_ctrl.sv
// Write channel controller: captures AW and W in any order, issues a one-cycle
// commit once both are held, then holds the B response until accepted.
//
// state   | meaning
// WR_IDLE | nothing held, AW and W both accepted
// WR_AW   | address held, waiting for data
// WR_W    | data held, waiting for address
// WR_BOTH | both held, commit this cycle
// WR_RESP | bvalid high, waiting for bready; no new AW/W taken
module axil_csr_wr_ctrl
  import axil_pkg::*;
#(
  parameter int N_REGS = 16,
  parameter int IDX_W  = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [AXIL_ADDR_W-1:0]   awaddr,
  input  logic                     wvalid,
  output logic                     wready,
  input  logic [AXIL_DATA_W-1:0]   wdata,
  input  logic [AXIL_DATA_W/8-1:0] wstrb,
  output logic                     bvalid,
  input  logic                     bready,
  output logic [1:0]               bresp,
  output logic                     commit,
  output logic                     commit_ok,
  output logic [IDX_W-1:0]         commit_idx,
  output logic [AXIL_DATA_W-1:0]   commit_data,
  output logic [AXIL_DATA_W/8-1:0] commit_strb
);

  wr_state_e                state_q, state_d;
  logic [29:0]              waddr_q, waddr_d;
  logic [AXIL_DATA_W-1:0]   wdata_q, wdata_d;
  logic [AXIL_DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [1:0]               bresp_q, bresp_d;
  logic                     aw_hs, w_hs;
  logic                     addr_lsb_unused;

  // Byte offset within the word carries no meaning for a 32-bit register.
  assign addr_lsb_unused = ^awaddr[1:0];

  assign awready     = (state_q == WR_IDLE) || (state_q == WR_W);
  assign wready      = (state_q == WR_IDLE) || (state_q == WR_AW);
  assign bvalid      = (state_q == WR_RESP);
  assign bresp       = bresp_q;
  assign aw_hs       = awvalid && awready;
  assign w_hs        = wvalid && wready;
  assign commit      = (state_q == WR_BOTH);
  assign commit_ok   = (waddr_q < 30'(N_REGS));
  assign commit_idx  = waddr_q[IDX_W-1:0];
  assign commit_data = wdata_q;
  assign commit_strb = wstrb_q;

  // Next-state: capture AW/W on handshake, commit when both held, release on bready.
  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    bresp_d = bresp_q;
    if (aw_hs) waddr_d = awaddr[31:2];
    if (w_hs) begin
      wdata_d = wdata;
      wstrb_d = wstrb;
    end
    unique case (state_q)
      WR_IDLE: begin
        if (aw_hs && w_hs) state_d = WR_BOTH;
        else if (aw_hs)    state_d = WR_AW;
        else if (w_hs)     state_d = WR_W;
      end
      WR_AW:   if (w_hs)  state_d = WR_BOTH;
      WR_W:    if (aw_hs) state_d = WR_BOTH;
      WR_BOTH: begin
        state_d = WR_RESP;
        bresp_d = commit_ok ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
      end
      WR_RESP: if (bready) state_d = WR_IDLE;
      default: state_d = WR_IDLE;
    endcase
  end

  // State and captured-transaction registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= WR_IDLE;
      waddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bresp_q <= AXIL_RESP_OKAY;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      bresp_q <= bresp_d;
    end
  end

endmodule

// File: rtl/axil_csr_slave.sv
// AXI-Lite CSR bank: N_REGS byte-writable 32-bit registers exposed as a flat
// vector with a per-register commit pulse; single-beat read path.
module axil_csr_slave
  import axil_pkg::*;
#(
  parameter int N_REGS = 16,
  parameter int IDX_W  = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  axil_csr_slave_if.slave               s_axil,
  output logic [N_REGS*AXIL_DATA_W-1:0] reg_q,
  output logic [N_REGS-1:0]             reg_wr_pulse
);

  logic [N_REGS-1:0][AXIL_DATA_W-1:0] regs_q, regs_d;
  logic [N_REGS-1:0]                  pulse_q, pulse_d;
  logic                               rvalid_q, rvalid_d;
  logic [AXIL_DATA_W-1:0]             rdata_q, rdata_d;
  logic [1:0]                         rresp_q, rresp_d;

  logic                     commit, commit_ok;
  logic [IDX_W-1:0]         commit_idx;
  logic [AXIL_DATA_W-1:0]   commit_data;
  logic [AXIL_DATA_W/8-1:0] commit_strb;
  logic                     ar_hs, ar_in_range;
  logic [IDX_W-1:0]         ar_idx;
  logic                     araddr_lsb_unused;

  axil_csr_wr_ctrl #(
    .N_REGS (N_REGS),
    .IDX_W  (IDX_W)
  ) u_wr_ctrl (
    .clk         (clk),
    .rstn        (rstn),
    .awvalid     (s_axil.awvalid),
    .awready     (s_axil.awready),
    .awaddr      (s_axil.awaddr),
    .wvalid      (s_axil.wvalid),
    .wready      (s_axil.wready),
    .wdata       (s_axil.wdata),
    .wstrb       (s_axil.wstrb),
    .bvalid      (s_axil.bvalid),
    .bready      (s_axil.bready),
    .bresp       (s_axil.bresp),
    .commit      (commit),
    .commit_ok   (commit_ok),
    .commit_idx  (commit_idx),
    .commit_data (commit_data),
    .commit_strb (commit_strb)
  );

  assign araddr_lsb_unused = ^s_axil.araddr[1:0];

  assign reg_q          = regs_q;
  assign reg_wr_pulse   = pulse_q;
  assign s_axil.arready = !rvalid_q;
  assign s_axil.rvalid  = rvalid_q;
  assign s_axil.rdata   = rdata_q;
  assign s_axil.rresp   = rresp_q;

  assign ar_hs       = s_axil.arvalid && !rvalid_q;
  assign ar_in_range = (s_axil.araddr[31:2] < 30'(N_REGS));
  assign ar_idx      = s_axil.araddr[IDX_W+1:2];

  // Register update on an in-range commit; reads sample pre-commit contents.
  always_comb begin
    regs_d   = regs_q;
    pulse_d  = '0;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (commit && commit_ok) begin
      regs_d[commit_idx]  = apply_wstrb(regs_q[commit_idx], commit_data, commit_strb);
      pulse_d[commit_idx] = 1'b1;
    end
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = ar_in_range ? regs_q[ar_idx] : '0;
      rresp_d  = ar_in_range ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
    end else if (rvalid_q && s_axil.rready) begin
      rvalid_d = 1'b0;
    end
  end

  // Register array, commit pulse and R channel with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      regs_q   <= '0;
      pulse_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= AXIL_RESP_OKAY;
    end else begin
      regs_q   <= regs_d;
      pulse_q  <= pulse_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axil_csr_slave.sv
// Directed bench for axil_csr_slave: B/R expectations are queued by the
// stimulus and checked by a monitor on each response handshake.
module tb_axil_csr_slave;
  localparam int N = 16;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
  } rexp_t;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N*32-1:0] reg_q;
  logic [N-1:0]    reg_wr_pulse;

  int          errors = 0;
  int          checks = 0;
  logic [1:0]  b_exp[$];
  rexp_t       r_exp[$];
  logic [31:0] exp_reg[N];
  logic [N-1:0] p;

  axil_csr_slave_if bus();

  axil_csr_slave #(.N_REGS(N)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .s_axil       (bus),
    .reg_q        (reg_q),
    .reg_wr_pulse (reg_wr_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rg(input int i);
    return reg_q[32*i +: 32];
  endfunction

  // Response monitor: compares each B/R handshake against the queued expectation.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.bvalid && bus.bready) begin
        if (b_exp.size() == 0) chk("b_unexpected", 32'(bus.bvalid), 32'd0);
        else chk("bresp", 32'(bus.bresp), 32'(b_exp.pop_front()));
      end
      if (bus.rvalid && bus.rready) begin
        if (r_exp.size() == 0) chk("r_unexpected", 32'(bus.rvalid), 32'd0);
        else begin
          rexp_t e;
          e = r_exp.pop_front();
          chk("rdata", bus.rdata, e.d);
          chk("rresp", 32'(bus.rresp), 32'(e.r));
        end
      end
    end
  end

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] er, output logic [N-1:0] pulses);
    int n;
    logic aw_hs, w_hs;
    pulses = '0;
    b_exp.push_back(er);
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    n = 0;
    while ((bus.awvalid || bus.wvalid) && n < 20) begin
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      step();
      pulses |= reg_wr_pulse;
      if (aw_hs) bus.awvalid = 1'b0;
      if (w_hs)  bus.wvalid  = 1'b0;
      n++;
    end
    chk("wr_addr_data_accepted", 32'(bus.awvalid | bus.wvalid), 32'd0);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 20) begin
      step();
      pulses |= reg_wr_pulse;
      n++;
    end
    chk("wr_bvalid_seen", 32'(bus.bvalid), 32'd1);
    step();
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
    int n;
    rexp_t e;
    e.d = ed; e.r = er;
    r_exp.push_back(e);
    bus.araddr = a; bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 20) begin step(); n++; end
    step();
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < 20) begin step(); n++; end
    chk("rd_rvalid_seen", 32'(bus.rvalid), 32'd1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    bus.awvalid = 0; bus.awaddr = 0; bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0;
    bus.bready = 1; bus.arvalid = 0; bus.araddr = 0; bus.rready = 1;
    for (int i = 0; i < N; i++) exp_reg[i] = 32'h0;
    repeat (3) step();
    rstn = 1'b1;

    // Reset state
    chk("rst_awready", 32'(bus.awready), 1);
    chk("rst_wready", 32'(bus.wready), 1);
    chk("rst_arready", 32'(bus.arready), 1);
    chk("rst_bvalid", 32'(bus.bvalid), 0);
    chk("rst_rvalid", 32'(bus.rvalid), 0);
    chk("rst_pulse", 32'(reg_wr_pulse), 0);
    chk("rst_regs_zero", 32'(|reg_q), 0);

    // AW+W same cycle to 0x08: bvalid two cycles later with reg_q and pulse
    bus.awaddr = 32'h08; bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF;
    bus.awvalid = 1; bus.wvalid = 1;
    b_exp.push_back(2'b00);
    chk("t1_awready", 32'(bus.awready), 1);
    chk("t1_wready", 32'(bus.wready), 1);
    step();
    bus.awvalid = 0; bus.wvalid = 0;
    chk("t1_bvalid_c1", 32'(bus.bvalid), 0);
    chk("t1_reg2_c1", rg(2), 32'h0);
    step();
    chk("t1_bvalid_c2", 32'(bus.bvalid), 1);
    chk("t1_reg2", rg(2), 32'hDEADBEEF);
    chk("t1_pulse", 32'(reg_wr_pulse), 32'h0004);
    step();
    chk("t1_pulse_gone", 32'(reg_wr_pulse), 0);
    exp_reg[2] = 32'hDEADBEEF;
    bus.araddr = 32'h08; bus.arvalid = 1;
    r_exp.push_back('{d: 32'hDEADBEEF, r: 2'b00});
    chk("t1_arready", 32'(bus.arready), 1);
    step();
    bus.arvalid = 0;
    chk("t1_rvalid", 32'(bus.rvalid), 1);
    step();
    chk("t1_rvalid_gone", 32'(bus.rvalid), 0);

    // W three cycles ahead of AW, partial strobe
    axi_write(32'h04, 32'h11223344, 4'hF, 2'b00, p);
    chk("t2_pre_pulse", 32'(p), 32'h0002);
    bus.wdata = 32'hAABBCCDD; bus.wstrb = 4'b0101; bus.wvalid = 1;
    chk("t2_wready", 32'(bus.wready), 1);
    step();
    bus.wvalid = 0;
    for (int i = 0; i < 2; i++) begin
      chk("t2_wready_low", 32'(bus.wready), 0);
      chk("t2_reg1_hold", rg(1), 32'h11223344);
      step();
    end
    bus.awaddr = 32'h04; bus.awvalid = 1;
    b_exp.push_back(2'b00);
    chk("t2_awready", 32'(bus.awready), 1);
    step();
    bus.awvalid = 0;
    step();
    chk("t2_bvalid", 32'(bus.bvalid), 1);
    chk("t2_reg1", rg(1), 32'h11BB33DD);
    chk("t2_pulse", 32'(reg_wr_pulse), 32'h0002);
    step();
    exp_reg[1] = 32'h11BB33DD;

    // bready held low for 5 cycles with a second write waiting
    bus.bready = 0;
    bus.awaddr = 32'h08; bus.wdata = 32'h00001234; bus.wstrb = 4'hF;
    bus.awvalid = 1; bus.wvalid = 1;
    b_exp.push_back(2'b00);
    step();
    bus.awvalid = 0; bus.wvalid = 0;
    step();
    exp_reg[2] = 32'h00001234;
    bus.awaddr = 32'h14; bus.wdata = 32'h000000A5; bus.awvalid = 1; bus.wvalid = 1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_bvalid_hold", 32'(bus.bvalid), 1);
      chk("t3_bresp_hold", 32'(bus.bresp), 0);
      chk("t3_awready_low", 32'(bus.awready), 0);
      chk("t3_wready_low", 32'(bus.wready), 0);
      step();
    end
    bus.bready = 1;
    b_exp.push_back(2'b00);
    step();
    chk("t3_bvalid_done", 32'(bus.bvalid), 0);
    chk("t3_awready_after", 32'(bus.awready), 1);
    chk("t3_wready_after", 32'(bus.wready), 1);
    step();
    bus.awvalid = 0; bus.wvalid = 0;
    step();
    chk("t3_bvalid2", 32'(bus.bvalid), 1);
    chk("t3_reg5", rg(5), 32'h000000A5);
    chk("t3_pulse2", 32'(reg_wr_pulse), 32'h0020);
    step();
    exp_reg[5] = 32'h000000A5;
    axi_read(32'h08, 32'h00001234, 2'b00);

    // Out-of-range write and read
    axi_write(32'h40, 32'hCAFEF00D, 4'hF, 2'b10, p);
    chk("t4_pulse_none", 32'(p), 0);
    for (int i = 0; i < N; i++) chk("t4_reg_unchanged", rg(i), exp_reg[i]);
    axi_read(32'h40, 32'h0, 2'b10);
    axi_read(32'h7FC, 32'h0, 2'b10);

    // Empty strobe still commits and pulses; byte offset bits ignored
    axi_write(32'h07, 32'hFFFFFFFF, 4'h0, 2'b00, p);
    chk("strb0_pulse", 32'(p), 32'h0002);
    chk("strb0_reg1", rg(1), 32'h11BB33DD);

    // AR in the commit cycle of the same register returns the old value
    bus.awaddr = 32'h0C; bus.wdata = 32'h5; bus.wstrb = 4'hF;
    bus.awvalid = 1; bus.wvalid = 1;
    b_exp.push_back(2'b00);
    step();
    bus.awvalid = 0; bus.wvalid = 0;
    bus.araddr = 32'h0C; bus.arvalid = 1;
    r_exp.push_back('{d: 32'h0, r: 2'b00});
    chk("t5_arready", 32'(bus.arready), 1);
    step();
    bus.arvalid = 0;
    chk("t5_rvalid", 32'(bus.rvalid), 1);
    chk("t5_reg3", rg(3), 32'h5);
    step();
    exp_reg[3] = 32'h5;
    axi_read(32'h0C, 32'h5, 2'b00);
    axi_read(32'h16, 32'h000000A5, 2'b00);

    // Reset with AW held and a read response pending
    bus.awaddr = 32'h10; bus.awvalid = 1;
    step();
    bus.awvalid = 0;
    chk("t6_aw_held", 32'(bus.awready), 0);
    bus.rready = 0; bus.araddr = 32'h04; bus.arvalid = 1;
    step();
    bus.arvalid = 0;
    chk("t6_rvalid", 32'(bus.rvalid), 1);
    step();
    chk("t6_rdata_hold", bus.rdata, 32'h11BB33DD);
    rstn = 0;
    step();
    rstn = 1; bus.rready = 1;
    for (int i = 0; i < N; i++) exp_reg[i] = 32'h0;
    chk("t6_bvalid", 32'(bus.bvalid), 0);
    chk("t6_bresp", 32'(bus.bresp), 0);
    chk("t6_rvalid0", 32'(bus.rvalid), 0);
    chk("t6_rdata0", bus.rdata, 0);
    chk("t6_rresp0", 32'(bus.rresp), 0);
    chk("t6_pulse", 32'(reg_wr_pulse), 0);
    chk("t6_regs_zero", 32'(|reg_q), 0);
    chk("t6_awready", 32'(bus.awready), 1);
    bus.wdata = 32'hFFFFFFFF; bus.wstrb = 4'hF; bus.wvalid = 1;
    step();
    bus.wvalid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t6_no_commit_bvalid", 32'(bus.bvalid), 0);
      chk("t6_no_commit_pulse", 32'(reg_wr_pulse), 0);
      chk("t6_reg4_zero", rg(4), 0);
      step();
    end
    bus.awaddr = 32'h10; bus.awvalid = 1;
    b_exp.push_back(2'b00);
    step();
    bus.awvalid = 0;
    step();
    chk("t6_bvalid_new", 32'(bus.bvalid), 1);
    chk("t6_reg4", rg(4), 32'hFFFFFFFF);
    chk("t6_pulse_new", 32'(reg_wr_pulse), 32'h0010);
    step();
    step();

    chk("b_queue_drained", 32'(b_exp.size()), 0);
    chk("r_queue_drained", 32'(r_exp.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axil_csr_slave.md
Name: axil_csr_slave

Overview:
- AXI-Lite slave register bank that sits directly downstream of the APB-to-AXI-Lite bridge and consumes its transactions.
- Holds N_REGS 32-bit control/status registers with per-byte write strobes.
- Exposes the registers as a flat vector, plus a one-cycle write pulse per register, to the tile logic behind it.
- AW and W are accepted independently and in any order. Each write and each read gets exactly one response.

Parameters:
- N_REGS, 16, number of 32-bit registers; legal range 1..256.
- IDX_W, $clog2(N_REGS) (min 1), width of the word index taken from addr[IDX_W+1:2].

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- s_axil_awvalid  in  1  write address valid
- s_axil_awready  out  1  write address ready
- s_axil_awaddr  in  32  byte address
- s_axil_wvalid  in  1  write data valid
- s_axil_wready  out  1  write data ready
- s_axil_wdata  in  32  write data
- s_axil_wstrb  in  4  byte enables
- s_axil_bvalid  out  1  write response valid
- s_axil_bready  in  1  write response ready
- s_axil_bresp  out  2  00 OKAY, 10 SLVERR
- s_axil_arvalid  in  1  read address valid
- s_axil_arready  out  1  read address ready
- s_axil_araddr  in  32  byte address
- s_axil_rvalid  out  1  read data valid
- s_axil_rready  in  1  read data ready
- s_axil_rdata  out  32  read data
- s_axil_rresp  out  2  00 OKAY, 10 SLVERR
- reg_q  out  N_REGS*32  register contents; register i occupies bits [32i+31:32i]
- reg_wr_pulse  out  N_REGS  one-cycle pulse on the cycle a register is committed

Behaviour:
- Reset (synchronous, rstn=0 at posedge clk): all of the following are 0 on the next edge:
  - registers, reg_wr_pulse
  - aw_held, w_held
  - bvalid, bresp, rvalid, rresp, rdata
- Reset mid-transaction drops any held AW/W and any pending response. No commit occurs.
- Decode:
  - index = addr[IDX_W+1:2]; addr[1:0] is ignored.
  - The address is in range iff addr[31:2] < N_REGS.
  - Out-of-range access returns SLVERR. Out-of-range writes change no register; out-of-range reads return rdata=0.
- Write FSM:
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid (combinational from registered state).
  - An AW handshake latches the address and sets aw_held. A W handshake latches data and strobe and sets w_held. Both may handshake in the same cycle.
  - Commit happens in the cycle after both are held:
    - For each byte b with wstrb[b]=1, reg[index][8b+7:8b] <= wdata byte.
    - reg_wr_pulse[index] is high for exactly that one cycle, and only when in range.
    - bvalid <= 1 with bresp set; aw_held and w_held are cleared.
  - Latency: AW+W in cycle 0 -> bvalid in cycle 2; reg_q is updated at the same edge.
  - bvalid and bresp are held stable until bready. No new AW/W is accepted while bvalid=1.
  - A response handshake with new AW/W present: the new AW/W is accepted in the cycle after the B handshake.
  - wstrb=0000 still commits, leaves data unchanged, pulses reg_wr_pulse and returns OKAY.
- Read FSM:
  - arready = !rvalid.
  - An AR handshake registers rdata and rresp from the current reg_q and sets rvalid on the next edge (1-cycle latency).
  - rvalid, rdata and rresp are held until rready.
  - A new AR is accepted in the cycle after the R handshake.
- Simultaneous events:
  - Read and write channels are fully independent.
  - A read whose AR handshake occurs in the same cycle as a commit to the same register returns the pre-commit value.
- Protocol rule: a valid is never waited on a ready; the slave never lowers awready/wready/arready after a valid without a handshake or reset.

Decomposition:
- Shared package axil_pkg:
  - constants AXIL_RESP_OKAY=2'b00, AXIL_RESP_SLVERR=2'b10, AXIL_DATA_W=32, AXIL_ADDR_W=32
  - function apply_wstrb(old, data, strb)
- Sub-module axil_csr_wr_ctrl: AW/W capture, commit strobe, B channel.
- The read path and register array stay in the top module.

Test Plan:
- Write 0xDEADBEEF with wstrb=1111 to 0x08 (AW and W in the same cycle) -> bvalid at cycle+2, bresp=00, reg_q[95:64]=0xDEADBEEF, reg_wr_pulse=0x0004 for one cycle. Then read 0x08 -> rvalid one cycle after the AR handshake, rdata=0xDEADBEEF, rresp=00.
- W sent 3 cycles before AW; with reg1=0x11223344, write 0xAABBCCDD wstrb=0101 to 0x04 -> wready drops after the W handshake, commit follows AW, reg1=0x11BB33DD.
- Hold bready=0 for 5 cycles after a write -> bvalid/bresp stable, awready=wready=0 throughout, a second AW is accepted only after the B handshake.
- Write then read address 0x40 with N_REGS=16 -> bresp=10, no reg_q change, reg_wr_pulse=0; rresp=10, rdata=0.
- AR to 0x0C in the same cycle as a commit of 0x5 to reg3 (old value 0x0) -> rdata=0x0; a subsequent read returns 0x5.
- Assert rstn=0 while aw_held=1 and rvalid=1 -> all outputs 0 next cycle; the pending W after reset creates no commit without a new AW.
